mips_run_ctrl: RTL and testbench

Run-sequencer for the MIPS core. It accepts a program streamed from a host over a valid/ready handshake and writes it word-by-word into instruction RAM. It then releases the core, counts execution cycles until halt, timeout or abort, and reports completion status. It sits between the host/testbench interface and the ram_instr write port and the mips_core running input.

---
 rtl/mips_run_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// mips_run_ctrl
//
// Run sequencer for the MIPS core. A program of n words is streamed in from
// the host and written word-by-word into instruction RAM. The core is then
// released and its execution cycles are counted until it halts, times out or
// is aborted. The controller then reports a completion status.
//
// Handshake (host -> controller load stream): a word transfers on every
// rising clk edge where ld_valid && ld_ready, except in a cycle where abort
// is high. ld_ready depends only on the state (high exactly in LOAD). The
// host may hold ld_valid low for any number of cycles.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start_flag        start request, sampled in IDLE and DONE only
//   n, timeout        program length / RUN cycle limit (0 = none), latched on start
//   abort             cancel the current LOAD or RUN
//   ld_valid/ld_data  host instruction stream, ld_ready back to the host
//   imem_wr_en/addr/wr_data  instruction RAM write port (byte address)
//   core_run/core_halt       core enable / core halt indication
//   busy, done, err, cycle_cnt  status (err valid while done=1)
//   dbg_state         current FSM state (IDLE=0, LOAD=1, RUN=2, DONE=3)
// -----------------------------------------------------------------------------
module mips_run_ctrl #(
    parameter int IMEM_DEPTH = 1024,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_flag,
    input  logic [31:0]      n,
    input  logic [CNT_W-1:0] timeout,
    input  logic             abort,
    input  logic             ld_valid,
    input  logic [31:0]      ld_data,
    output logic             ld_ready,
    output logic             imem_wr_en,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wr_data,
    output logic             core_run,
    input  logic             core_halt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SIZE    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    state_t           state_q, state_d;
    logic [31:0]      n_q, n_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;
    logic [31:0]      wc_q, wc_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             size_err;
    logic             handshake;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt_sat;

    assign size_err    = (n == 32'd0) || (n > 32'(IMEM_DEPTH));
    // abort wins over a word offered in the same cycle, so the write is suppressed
    assign handshake   = (state_q == S_LOAD) && ld_valid && !abort;
    assign timeout_hit = (timeout_q != '0) && (cnt_q == timeout_q - CNT_W'(1));
    assign cnt_sat     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        timeout_d = timeout_q;
        wc_d      = wc_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_flag) begin
                    if (size_err) begin
                        state_d = S_DONE;
                        err_d   = ERR_SIZE;
                        cnt_d   = '0;
                    end else begin
                        state_d   = S_LOAD;
                        n_d       = n;
                        timeout_d = timeout;
                        wc_d      = 32'd0;
                        err_d     = ERR_OK;
                        cnt_d     = '0;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_DONE;
                    err_d   = ERR_ABORT;
                end else if (handshake) begin
                    wc_d = wc_q + 32'd1;
                    if (wc_q == n_q - 32'd1) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end
            end
            S_RUN: begin
                // the terminating cycle is still counted
                cnt_d = cnt_sat;
                if (abort) begin
                    state_d = S_DONE;
                    err_d   = ERR_ABORT;
                end else if (core_halt) begin
                    state_d = S_DONE;
                    err_d   = ERR_OK;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    err_d   = ERR_TIMEOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            n_q       <= 32'd0;
            timeout_q <= '0;
            wc_q      <= 32'd0;
            err_q     <= ERR_OK;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            timeout_q <= timeout_d;
            wc_q      <= wc_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // status strobes come from the state register only
    assign ld_ready     = (state_q == S_LOAD);
    assign core_run     = (state_q == S_RUN);
    assign busy         = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done         = (state_q == S_DONE);
    assign err          = err_q;
    assign cycle_cnt    = cnt_q;
    assign dbg_state    = state_q;

    assign imem_wr_en   = handshake;
    assign imem_addr    = (state_q == S_LOAD) ? {wc_q[29:0], 2'b00} : 32'd0;
    assign imem_wr_data = (state_q == S_LOAD) ? ld_data : 32'd0;

endmodule

// File: tb/tb_mips_run_ctrl.sv
module tb_mips_run_ctrl;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_flag;
    logic [31:0]      n;
    logic [CNT_W-1:0] timeout;
    logic             abort;
    logic             ld_valid;
    logic [31:0]      ld_data;
    logic             ld_ready;
    logic             imem_wr_en;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_wr_data;
    logic             core_run;
    logic             core_halt;
    logic             busy;
    logic             done;
    logic [1:0]       err;
    logic [CNT_W-1:0] cycle_cnt;
    logic [1:0]       dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    int run_cycles  = 0;
    logic [63:0] exp_q[$];

    mips_run_ctrl #(.IMEM_DEPTH(1024), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_flag   (start_flag),
        .n            (n),
        .timeout      (timeout),
        .abort        (abort),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_addr    (imem_addr),
        .imem_wr_data (imem_wr_data),
        .core_run     (core_run),
        .core_halt    (core_halt),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cycle_cnt    (cycle_cnt),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // write scoreboard and RUN-cycle counter, sampled mid-cycle
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && core_run) run_cycles++;
        if (rst_n && imem_wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(imem_wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("imem_write", {imem_addr, imem_wr_data}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [31:0] nn, input logic [31:0] tt);
        start_flag = 1'b1;
        n          = nn;
        timeout    = tt;
        tick();
        start_flag = 1'b0;
    endtask

    // mode 0: back-to-back, 1: one bubble between words, 2: random bubbles
    task automatic load_words(input int nn, input int mode);
        for (int i = 0; i < nn; i++) begin
            int gaps;
            gaps = (mode == 1) ? ((i > 0) ? 1 : 0) :
                   (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                ld_valid = 1'b0;
                ld_data  = $urandom;
                #1;
                chk("ld_ready_bubble", 64'(ld_ready), 64'd1);
                chk("wr_en_bubble", 64'(imem_wr_en), 64'd0);
                tick();
            end
            ld_valid = 1'b1;
            ld_data  = $urandom;
            exp_q.push_back({32'(i * 4), ld_data});
            tick();
        end
        ld_valid = 1'b0;
    endtask

    // RUN phase against a reference: the run ends at the earliest event cycle,
    // err chosen by abort > halt > timeout, cycle_cnt = that cycle number
    task automatic run_phase(input int halt_at, input int abort_at, input int tt);
        int k;
        int end_c;
        logic [1:0] e_err;
        end_c = 0;
        if (halt_at > 0) end_c = halt_at;
        if (tt > 0 && (end_c == 0 || tt < end_c)) end_c = tt;
        if (abort_at > 0 && (end_c == 0 || abort_at < end_c)) end_c = abort_at;
        e_err = (abort_at == end_c) ? 2'b11 : (halt_at == end_c) ? 2'b00 : 2'b10;

        chk("run_entered", 64'(core_run), 64'd1);
        k = 1;
        while (core_run === 1'b1 && k <= 300) begin
            core_halt = (k == halt_at);
            abort     = (k == abort_at);
            tick();
            k++;
        end
        core_halt = 1'b0;
        abort     = 1'b0;
        chk("run_done", 64'(done), 64'd1);
        chk("run_busy", 64'(busy), 64'd0);
        chk("run_err", 64'(err), 64'(e_err));
        chk("run_cycle_cnt", 64'(cycle_cnt), 64'(end_c));
        chk("run_core_run_cycles", 64'(run_cycles), 64'(end_c));
        chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic transaction(input int nn, input int tt, input int halt_at,
                               input int abort_at, input int mode);
        run_cycles = 0;
        drive_start(32'(nn), 32'(tt));
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_ld_ready", 64'(ld_ready), 64'd1);
        chk("start_done", 64'(done), 64'd0);
        chk("start_err", 64'(err), 64'd0);
        load_words(nn, mode);
        run_phase(halt_at, abort_at, tt);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n      = 1'b1;
        start_flag = 1'b0;
        n          = 32'd0;
        timeout    = '0;
        abort      = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = 32'd0;
        core_halt  = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_state", 64'(dbg_state), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_core_run", 64'(core_run), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        rst_n = 1'b1;
        tick();

        // n=3 back-to-back, halt in 5th RUN cycle
        transaction(3, 0, 5, 0, 0);
        // n=4 with ld_valid toggling
        transaction(4, 0, 2, 0, 1);

        // size errors from DONE, with ld_valid held high to tempt a write
        ld_valid = 1'b1;
        ld_data  = $urandom;
        run_cycles = 0;
        drive_start(32'd0, 32'd0);
        chk("size0_done", 64'(done), 64'd1);
        chk("size0_err", 64'(err), 64'd1);
        chk("size0_cnt", 64'(cycle_cnt), 64'd0);
        chk("size0_run", 64'(core_run), 64'd0);
        drive_start(32'd1025, 32'd0);
        chk("size1025_done", 64'(done), 64'd1);
        chk("size1025_err", 64'(err), 64'd1);
        chk("size1025_busy", 64'(busy), 64'd0);
        tick();
        ld_valid = 1'b0;
        chk("size_no_run", 64'(run_cycles), 64'd0);

        // timeout only, then halt coinciding with timeout
        transaction(1, 10, 0, 0, 0);
        transaction(1, 10, 10, 0, 0);
        // abort coinciding with halt
        transaction(2, 0, 3, 3, 0);

        // abort during the 2nd load word
        run_cycles = 0;
        drive_start(32'd3, 32'd0);
        ld_valid = 1'b1;
        ld_data  = $urandom;
        exp_q.push_back({32'd0, ld_data});
        tick();
        ld_data = $urandom;
        abort   = 1'b1;
        #1;
        chk("abort_ld_ready", 64'(ld_ready), 64'd1);
        chk("abort_wr_en", 64'(imem_wr_en), 64'd0);
        tick();
        abort    = 1'b0;
        ld_valid = 1'b0;
        chk("abort_done", 64'(done), 64'd1);
        chk("abort_err", 64'(err), 64'd3);
        chk("abort_no_run", 64'(run_cycles), 64'd0);
        chk("abort_writes", 64'(exp_q.size()), 64'd0);
        // restart from DONE: err clears, loads from address 0
        transaction(2, 0, 1, 0, 0);

        // start ignored in RUN, then asynchronous reset mid-RUN
        run_cycles = 0;
        drive_start(32'd1, 32'd0);
        load_words(1, 0);
        tick();
        tick();
        start_flag = 1'b1;
        n          = 32'd5;
        tick();
        start_flag = 1'b0;
        chk("start_in_run_run", 64'(core_run), 64'd1);
        chk("start_in_run_ld_ready", 64'(ld_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_run", 64'(core_run), 64'd0);
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        chk("midrun_rst_done", 64'(done), 64'd0);
        chk("midrun_rst_err", 64'(err), 64'd0);
        chk("midrun_rst_cnt", 64'(cycle_cnt), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        transaction(2, 0, 3, 0, 2);

        // randomized transactions
        for (int t = 0; t < 20; t++) begin
            int nn, tt, h, a;
            nn = int'($urandom_range(1, 8));
            tt = int'($urandom_range(0, 12));
            h  = int'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
            if (tt == 0 && h == 0 && a == 0) h = int'($urandom_range(1, 12));
            transaction(nn, tt, h, a, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
